// File: rtl/instruction_fetch.sv
// instruction_fetch: fetches 8-bit instruction words over req/ack into an IR, with PC, branch redirect, HALT and fetch timeout.
module instruction_fetch #(
    parameter int ADDR_WIDTH = 8,
    parameter int MAX_WAIT   = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fetch_next,
    input  logic                  branch_taken,
    input  logic [ADDR_WIDTH-1:0] branch_target,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_ack,
    input  logic [7:0]            mem_data,
    output logic [3:0]            opcode,
    output logic [3:0]            operand,
    output logic                  instr_valid,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic                  halted,
    output logic                  fetch_error
);
    typedef enum logic [2:0] {IDLE, FETCH, HOLD, HALT, ERROR} state_t;
    localparam logic [7:0] LAST = 8'(MAX_WAIT - 1);
    state_t                state, state_n;
    logic [ADDR_WIDTH-1:0] pc_n;
    logic [7:0]            ir, ir_n, cnt, cnt_n;
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            pc    <= '0;
            ir    <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            ir    <= ir_n;
            cnt   <= cnt_n;
        end
    end
    always_comb begin
        state_n = state;
        pc_n    = pc;
        ir_n    = ir;
        cnt_n   = cnt;
        case (state)
            IDLE: state_n = FETCH;
            FETCH: begin
                if (mem_ack) begin
                    ir_n    = mem_data;
                    pc_n    = pc + ADDR_WIDTH'(1);
                    cnt_n   = '0;
                    state_n = &mem_data[7:4] ? HALT : HOLD;
                end else if (cnt == LAST) begin
                    state_n = ERROR;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            HOLD: begin
                if (fetch_next) begin
                    state_n = FETCH;
                    cnt_n   = '0;
                    pc_n    = branch_taken ? branch_target : pc;
                end
            end
            default: ;
        endcase
    end
    // pc is zero in IDLE and frozen in HALT/ERROR, so mem_addr can track it directly
    assign mem_req     = state == FETCH;
    assign mem_addr    = pc;
    assign instr_valid = state == HOLD;
    assign halted      = state == HALT;
    assign fetch_error = state == ERROR;
    assign opcode      = ir[7:4];
    assign operand     = ir[3:0];
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed scenario tests for instruction_fetch with MAX_WAIT=4.
module tb_instruction_fetch;
    logic       clk = 0;
    logic       reset = 1;
    logic       fetch_next = 0;
    logic       branch_taken = 0;
    logic [7:0] branch_target = 0;
    logic       mem_req;
    logic [7:0] mem_addr;
    logic       mem_ack = 0;
    logic [7:0] mem_data = 0;
    logic [3:0] opcode, operand;
    logic       instr_valid;
    logic [7:0] pc;
    logic       halted, fetch_error;
    int         errors = 0;
    int         checks = 0;

    instruction_fetch #(.ADDR_WIDTH(8), .MAX_WAIT(4)) dut (
        .clk(clk), .reset(reset), .fetch_next(fetch_next), .branch_taken(branch_taken),
        .branch_target(branch_target), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_data(mem_data), .opcode(opcode), .operand(operand),
        .instr_valid(instr_valid), .pc(pc), .halted(halted), .fetch_error(fetch_error)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ack(input logic [7:0] d);
        mem_ack  = 1;
        mem_data = d;
        tick();
        mem_ack  = 0;
    endtask

    task automatic pulse_next(input logic bt, input logic [7:0] tgt);
        fetch_next    = 1;
        branch_taken  = bt;
        branch_target = tgt;
        tick();
        fetch_next   = 0;
        branch_taken = 0;
    endtask

    task automatic test_reset();
        reset = 1;
        tick();
        tick();
        reset = 0;
        checks++;
        if ({mem_req, instr_valid, halted, fetch_error, pc, mem_addr, opcode, operand} !== 28'h0) begin
            errors++;
            $display("FAIL reset_outputs: got req=%b v=%b h=%b e=%b pc=%h addr=%h op=%h opd=%h want all 0",
                     mem_req, instr_valid, halted, fetch_error, pc, mem_addr, opcode, operand);
        end
        tick();
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 8'h00) begin
            errors++;
            $display("FAIL first_req: got req=%b addr=%h want req=1 addr=00", mem_req, mem_addr);
        end
        tick();
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 8'h00) begin
            errors++;
            $display("FAIL first_req_wait: got req=%b addr=%h want req=1 addr=00", mem_req, mem_addr);
        end
        ack(8'h3A);
        checks++;
        if (opcode !== 4'h3 || operand !== 4'hA || instr_valid !== 1'b1 || pc !== 8'h01 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL first_fetch: got op=%h opd=%h v=%b pc=%h req=%b want 3 A 1 01 0",
                     opcode, operand, instr_valid, pc, mem_req);
        end
    endtask

    task automatic test_branch();
        branch_taken  = 1;
        branch_target = 8'h77;
        tick();
        branch_taken = 0;
        checks++;
        if (pc !== 8'h01 || instr_valid !== 1'b1 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL branch_no_next: got pc=%h v=%b req=%b want 01 1 0", pc, instr_valid, mem_req);
        end
        pulse_next(1, 8'h40);
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 8'h40 || pc !== 8'h40) begin
            errors++;
            $display("FAIL branch_addr: got req=%b addr=%h pc=%h want 1 40 40", mem_req, mem_addr, pc);
        end
        ack(8'h55);
        checks++;
        if (pc !== 8'h41 || opcode !== 4'h5 || operand !== 4'h5 || instr_valid !== 1'b1) begin
            errors++;
            $display("FAIL branch_fetch: got pc=%h op=%h opd=%h v=%b want 41 5 5 1", pc, opcode, operand, instr_valid);
        end
    endtask

    task automatic test_wrap();
        pulse_next(1, 8'hFF);
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 8'hFF) begin
            errors++;
            $display("FAIL wrap_addr: got req=%b addr=%h want 1 FF", mem_req, mem_addr);
        end
        ack(8'h21);
        checks++;
        if (pc !== 8'h00 || opcode !== 4'h2 || operand !== 4'h1 || instr_valid !== 1'b1) begin
            errors++;
            $display("FAIL wrap_pc: got pc=%h op=%h opd=%h v=%b want 00 2 1 1", pc, opcode, operand, instr_valid);
        end
    endtask

    task automatic test_stray();
        ack(8'hF3);
        checks++;
        if (opcode !== 4'h2 || operand !== 4'h1 || pc !== 8'h00 || instr_valid !== 1'b1 || halted !== 1'b0) begin
            errors++;
            $display("FAIL stray_ack: got op=%h opd=%h pc=%h v=%b h=%b want 2 1 00 1 0",
                     opcode, operand, pc, instr_valid, halted);
        end
        pulse_next(0, 8'h99);
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 8'h00) begin
            errors++;
            $display("FAIL seq_addr: got req=%b addr=%h want 1 00", mem_req, mem_addr);
        end
        fetch_next = 1;
        tick();
        fetch_next = 0;
        checks++;
        if (mem_req !== 1'b1 || opcode !== 4'h2 || pc !== 8'h00) begin
            errors++;
            $display("FAIL stray_next: got req=%b op=%h pc=%h want 1 2 00", mem_req, opcode, pc);
        end
        ack(8'h67);
        checks++;
        if (opcode !== 4'h6 || pc !== 8'h01 || instr_valid !== 1'b1) begin
            errors++;
            $display("FAIL stray_fetch: got op=%h pc=%h v=%b want 6 01 1", opcode, pc, instr_valid);
        end
        tick();
        checks++;
        if (instr_valid !== 1'b1 || mem_req !== 1'b0 || pc !== 8'h01) begin
            errors++;
            $display("FAIL not_queued: got v=%b req=%b pc=%h want 1 0 01", instr_valid, mem_req, pc);
        end
    endtask

    task automatic test_timeout_boundary();
        pulse_next(0, 8'h00);
        tick();
        tick();
        tick();
        checks++;
        if (mem_req !== 1'b1 || fetch_error !== 1'b0) begin
            errors++;
            $display("FAIL last_wait_cycle: got req=%b err=%b want 1 0", mem_req, fetch_error);
        end
        ack(8'h12);
        checks++;
        if (fetch_error !== 1'b0 || instr_valid !== 1'b1 || opcode !== 4'h1 || pc !== 8'h02) begin
            errors++;
            $display("FAIL boundary_ack: got err=%b v=%b op=%h pc=%h want 0 1 1 02", fetch_error, instr_valid, opcode, pc);
        end
    endtask

    task automatic test_timeout();
        int req_cycles = 0;
        pulse_next(0, 8'h00);
        for (int i = 0; i < 8; i++) begin
            if (mem_req === 1'b1) req_cycles++;
            tick();
        end
        checks++;
        if (req_cycles !== 4) begin
            errors++;
            $display("FAIL req_cycles: got %0d want 4", req_cycles);
        end
        checks++;
        if (fetch_error !== 1'b1 || mem_req !== 1'b0 || mem_addr !== 8'h02 || pc !== 8'h02 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL timeout_state: got err=%b req=%b addr=%h pc=%h v=%b want 1 0 02 02 0",
                     fetch_error, mem_req, mem_addr, pc, instr_valid);
        end
        mem_ack    = 1;
        mem_data   = 8'h44;
        fetch_next = 1;
        tick();
        tick();
        mem_ack    = 0;
        fetch_next = 0;
        checks++;
        if (fetch_error !== 1'b1 || mem_req !== 1'b0 || mem_addr !== 8'h02 || opcode !== 4'h1) begin
            errors++;
            $display("FAIL error_sticky: got err=%b req=%b addr=%h op=%h want 1 0 02 1", fetch_error, mem_req, mem_addr, opcode);
        end
    endtask

    task automatic test_halt();
        reset = 1;
        tick();
        reset = 0;
        tick();
        ack(8'hF0);
        checks++;
        if (halted !== 1'b1 || instr_valid !== 1'b0 || opcode !== 4'hF || pc !== 8'h01 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL halt_entry: got h=%b v=%b op=%h pc=%h req=%b want 1 0 F 01 0",
                     halted, instr_valid, opcode, pc, mem_req);
        end
        for (int i = 0; i < 4; i++) begin
            fetch_next    = 1;
            branch_taken  = i[0];
            branch_target = 8'h80;
            mem_ack       = 1;
            mem_data      = 8'h3C;
            tick();
            checks++;
            if (halted !== 1'b1 || mem_req !== 1'b0 || pc !== 8'h01 || opcode !== 4'hF) begin
                errors++;
                $display("FAIL halt_hold[%0d]: got h=%b req=%b pc=%h op=%h want 1 0 01 F", i, halted, mem_req, pc, opcode);
            end
        end
        fetch_next   = 0;
        branch_taken = 0;
        mem_ack      = 0;
        reset        = 1;
        tick();
        checks++;
        if ({mem_req, instr_valid, halted, fetch_error, pc, mem_addr, opcode, operand} !== 28'h0) begin
            errors++;
            $display("FAIL halt_reset: got req=%b v=%b h=%b e=%b pc=%h addr=%h op=%h opd=%h want all 0",
                     mem_req, instr_valid, halted, fetch_error, pc, mem_addr, opcode, operand);
        end
    endtask

    task automatic test_reset_mid_fetch();
        reset = 0;
        tick();
        reset    = 1;
        mem_ack  = 1;
        mem_data = 8'h9C;
        tick();
        reset = 0;
        checks++;
        if (mem_req !== 1'b0 || opcode !== 4'h0 || pc !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid_fetch: got req=%b op=%h pc=%h want 0 0 00", mem_req, opcode, pc);
        end
        tick();
        mem_ack = 0;
        checks++;
        if (mem_req !== 1'b1 || opcode !== 4'h0 || operand !== 4'h0 || pc !== 8'h00) begin
            errors++;
            $display("FAIL idle_ack_ignored: got req=%b op=%h opd=%h pc=%h want 1 0 0 00", mem_req, opcode, operand, pc);
        end
    endtask

    initial begin
        test_reset();
        test_branch();
        test_wrap();
        test_stray();
        test_timeout_boundary();
        test_timeout();
        test_halt();
        test_reset_mid_fetch();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
